synaptic_current_integrator: RTL
================================

Name: synaptic_current_integrator

Overview:
Upstream feeder for the LIF neuron. Accepts presynaptic spike events over a valid/ready handshake and looks up a per-synapse signed weight. It accumulates the weight into a saturating signed synaptic current and applies exponential decay once per timestep tick. Each timestep it publishes an 8-bit unsigned current plus a stop flag that drive the neuron's current/stop inputs directly.

Parameters:
N_SYN, 16, number of synapses (weight entries)
SYN_ID_W, 4, synapse id width, equal to clog2(N_SYN)
W_W, 8, signed weight width (two's complement)
ACC_W, 12, signed accumulator width
DECAY_SHIFT, 3, decay factor; per tick, acc loses acc>>>DECAY_SHIFT

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous, active-low reset
tick  in  1  timestep strobe, one cycle wide
spk_valid  in  1  spike event valid
spk_ready  out  1  spike event accept
spk_id  in  SYN_ID_W  presynaptic synapse index
w_we  in  1  weight write enable
w_addr  in  SYN_ID_W  weight write address
w_data  in  W_W  signed weight value
current  out  8  unsigned current to neuron: clamp(acc, 0, 255)
current_valid  out  1  one-cycle pulse when current/stop update
stop  out  1  high when published current == 0
sat_flag  out  1  sticky; set when the accumulator saturates
tick_ovr  out  1  sticky; set when a tick is dropped

Behaviour:
- Reset (clk edge with reset_n=0) acts regardless of state. It sets:
  - state=IDLE, acc=0, current=0, stop=1
  - current_valid=0, sat_flag=0, tick_ovr=0
  - tick_pend=0, all weights=0
  - Any in-flight spike or tick is discarded.
- FSM states are IDLE, ACC, DECAY and OUT.
- IDLE:
  - If tick or tick_pend is set, go to DECAY and clear tick_pend. Tick has priority over spikes.
  - Otherwise, a handshake (spk_valid & spk_ready) registers weight[spk_id] into w_q and goes to ACC.
- spk_ready = (state==IDLE) & ~tick & ~tick_pend. This is combinational.
- ACC:
  - acc <= sat(acc + sext(w_q)), with saturation to [-2048, 2047].
  - If saturation occurs, set sat_flag.
  - Go to IDLE.
  - Spike throughput is 1 per 2 cycles. spk_ready is low in ACC and high again the following cycle.
- DECAY:
  - Let d = acc>>>DECAY_SHIFT (arithmetic shift).
  - If d==0, acc <= 0. This flushes the residue: positive |acc| < 2^DECAY_SHIFT, and -1 after flooring.
  - Otherwise, acc <= acc - d.
  - Go to OUT.
- OUT:
  - current <= clamp(acc,0,255), where acc is the post-decay value.
  - stop <= (clamped value == 0).
  - current_valid <= 1. It lasts exactly 1 cycle, then returns to 0.
  - Go to IDLE.
- Latency: a tick sampled in IDLE at cycle T gives current/current_valid visible at T+3.
- Tick while not servicing (ACC, DECAY, OUT):
  - If tick_pend=0, set tick_pend.
  - If tick_pend=1, drop the tick and set tick_ovr.
- Weight write port:
  - Writes commit at the clock edge and are independent of the FSM.
  - A write and a spike lookup to the same address in the same cycle return the old weight (read-first).
- current and stop hold their values between OUT updates.
- Neither sticky flag clears except by reset.

Decomposition:
- Package snn_pkg holds:
  - the state enum (IDLE/ACC/DECAY/OUT)
  - ACC_MAX=2047 and ACC_MIN=-2048
  - CUR_MAX=255
  - shared width constants, which are reused by the neuron stage
- Sub-module syn_weight_rf is an N_SYN x W_W register file with a synchronous read-first lookup port, one write port, and clear on reset.
- The saturating add and the clamp are functions in snn_pkg.

Test Plan:
1. After reset, with no stimulus: current=0, stop=1, current_valid=0, spk_ready=1, sat_flag=0, tick_ovr=0.
2. Write w[3]=20. Send 3 spikes on id 3, then a tick.
   - acc after spikes = 60.
   - Decay: 60-7 = 53, so current=53, stop=0, current_valid pulses exactly at T+3.
   - A second tick gives 53-6 = 47, so current=47.
3. Write w[5]=-8 (0xF8). From acc=0, send a spike on id 5, then a tick.
   - acc: -8 becomes -7.
   - current=0, stop=1.
4. Write w[0]=127 and send 20 spikes.
   - acc=2047, sat_flag=1.
   - Tick: 2047-255 = 1792, so current=255.
   - A separate case with acc=5 and a tick gives acc=0, current=0, stop=1.
5. Drive tick and spk_valid in the same IDLE cycle.
   - spk_ready=0 that cycle.
   - The spike is accepted after OUT.
   - Two extra ticks during DECAY/OUT: one goes pending, one is dropped, and tick_ovr=1.
6. Write w[2]=9 in the same cycle as a spike on id 2 (old w[2]=4): acc +4. The next spike on id 2 gives +9. Assert reset_n=0 while in ACC: all outputs and weights return to reset values next cycle.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types, widths and arithmetic helpers for the spiking front-end
// (synaptic integrator and the LIF neuron stage).
package snn_pkg;

    localparam int N_SYN       = 16;
    localparam int SYN_ID_W    = 4;
    localparam int W_W         = 8;
    localparam int ACC_W       = 12;
    localparam int DECAY_SHIFT = 3;
    localparam int CUR_W       = 8;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 12'sd2047;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -12'sd2048;
    localparam logic [CUR_W-1:0]        CUR_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DECAY = 2'd2,
        ST_OUT   = 2'd3
    } sci_state_t;

    // One guard bit is enough: a W_W-bit weight can overflow ACC_W by at most one bit.
    function automatic logic signed [ACC_W:0] ext_sum(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [W_W-1:0]   w);
        ext_sum = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W+1-W_W){w[W_W-1]}}, w});
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] a,
                                     input logic signed [W_W-1:0]   w);
        logic signed [ACC_W:0] s;
        s       = ext_sum(a, w);
        sat_hit = (s[ACC_W] != s[ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [W_W-1:0]   w);
        logic signed [ACC_W:0] s;
        s = ext_sum(a, w);
        if (s[ACC_W] != s[ACC_W-1])
            sat_add = s[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            sat_add = s[ACC_W-1:0];
    endfunction

    function automatic logic [CUR_W-1:0] clamp_cur(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1])
            clamp_cur = '0;
        else if (a[ACC_W-2:CUR_W] != '0)
            clamp_cur = CUR_MAX;
        else
            clamp_cur = a[CUR_W-1:0];
    endfunction

endpackage

// File: rtl/syn_weight_rf.sv
// Per-synapse weight store: one write port, one registered read-first lookup port.
module syn_weight_rf
    import snn_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rd_en,
    input  logic [SYN_ID_W-1:0] rd_addr,
    output logic [W_W-1:0]      rd_data,
    input  logic                we,
    input  logic [SYN_ID_W-1:0] wr_addr,
    input  logic [W_W-1:0]      wr_data
);

    logic [W_W-1:0] mem [N_SYN];

    // Lookup samples mem before this edge's write lands, so same-address collisions see the old weight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SYN; i++)
                mem[i] <= '0;
            rd_data <= '0;
        end else begin
            if (we)
                mem[wr_addr] <= wr_data;
            if (rd_en)
                rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/synaptic_current_integrator.sv
// Spike-driven saturating current accumulator with per-tick exponential decay,
// publishing a clamped 8-bit current and stop flag to the LIF neuron.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; tick (or pending tick) wins over a spike handshake
//   ST_ACC   | add looked-up weight into acc with saturation
//   ST_DECAY | acc -= acc >>> DECAY_SHIFT, flushing the small residue
//   ST_OUT   | publish clamp(acc) and stop, pulse current_valid
module synaptic_current_integrator
    import snn_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                spk_valid,
    output logic                spk_ready,
    input  logic [SYN_ID_W-1:0] spk_id,
    input  logic                w_we,
    input  logic [SYN_ID_W-1:0] w_addr,
    input  logic [W_W-1:0]      w_data,
    output logic [CUR_W-1:0]    current,
    output logic                current_valid,
    output logic                stop,
    output logic                sat_flag,
    output logic                tick_ovr
);

    sci_state_t              state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_shr;
    logic [W_W-1:0]          w_q;
    logic                    tick_pend;
    logic                    spk_fire;

    assign spk_ready = (state == ST_IDLE) & ~tick & ~tick_pend;
    assign spk_fire  = spk_valid & spk_ready;
    assign acc_shr   = acc >>> DECAY_SHIFT;

    syn_weight_rf u_weight_rf (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (spk_fire),
        .rd_addr (spk_id),
        .rd_data (w_q),
        .we      (w_we),
        .wr_addr (w_addr),
        .wr_data (w_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            acc           <= '0;
            tick_pend     <= 1'b0;
            current       <= '0;
            stop          <= 1'b1;
            current_valid <= 1'b0;
            sat_flag      <= 1'b0;
            tick_ovr      <= 1'b0;
        end else begin
            current_valid <= 1'b0;

            // Only one tick can be buffered while busy; a second one is lost.
            if (tick && (state != ST_IDLE)) begin
                if (tick_pend)
                    tick_ovr <= 1'b1;
                else
                    tick_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (tick || tick_pend) begin
                        state     <= ST_DECAY;
                        tick_pend <= 1'b0;
                    end else if (spk_fire) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc <= sat_add(acc, w_q);
                    if (sat_hit(acc, w_q))
                        sat_flag <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_DECAY: begin
                    if (acc_shr == '0)
                        acc <= '0;
                    else
                        acc <= acc - acc_shr;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    current       <= clamp_cur(acc);
                    stop          <= (clamp_cur(acc) == '0);
                    current_valid <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
